panel_arbiter: RTL

Shares the single display panel among the game's display sources: the 7-segment bus (`seg`/`cat`) and the 8×8 bicolour dot matrix (`hang`/`red`/`gre`). Sources include password display, countdown, bomb animation and result faces. It replaces ad-hoc OR/AND merging of those buses with a request/grant scheme. Exactly one source drives the panel at a time. A blanking gap separates owners, and a minimum hold time prevents flicker. It sits between the display-producing blocks and the top-level panel pins.

---
 rtl/panel_arb_pkg.sv | 27 ++
 rtl/prio_pick.sv | 42 ++++
 rtl/panel_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/panel_arb_pkg.sv
// ---------------------------------------------------------------------------
// panel_arb_pkg
// Shared definitions for the display panel arbiter:
//   - state_t        : arbiter FSM states (IDLE, OWN, BLANK)
//   - *_IDLE         : values driven onto the panel while nobody owns it
//   - *_DEF          : default MIN_HOLD / BLANK_CYCLES parameter values
// ---------------------------------------------------------------------------
package panel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Idle panel: segments off, all digit cathodes and matrix rows
  // deasserted (active-low), no column colour.
  localparam logic [7:0] SEG_IDLE  = 8'h00;
  localparam logic [7:0] CAT_IDLE  = 8'hFF;
  localparam logic [7:0] HANG_IDLE = 8'hFF;
  localparam logic [7:0] RED_IDLE  = 8'h00;
  localparam logic [7:0] GRE_IDLE  = 8'h00;

  localparam int MIN_HOLD_DEF     = 16;
  localparam int BLANK_CYCLES_DEF = 2;

endpackage

// File: rtl/prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Fixed-priority encoder, index 0 highest. With mask_en set, only indices
// strictly below `limit` are eligible (used to look for requesters that
// outrank the current owner).
// Ports:
//   req     in  N   : request vector
//   mask_en in  1   : restrict eligibility to indices < limit
//   limit   in  IW  : exclusive upper bound on eligible indices
//   valid   out 1   : at least one eligible request
//   onehot  out N   : one-hot winner (all zero when !valid)
//   idx     out IW  : winner index (0 when !valid)
// ---------------------------------------------------------------------------
module prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic          mask_en,
  input  logic [IW-1:0] limit,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Scan from the lowest priority upward so the last hit, the lowest
  // eligible index, is the one left standing.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (!mask_en || (IW'(i) < limit))) begin
        valid     = 1'b1;
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/panel_arbiter.sv
// ---------------------------------------------------------------------------
// panel_arbiter
// Grants the shared 7-segment bus and 8x8 bicolour matrix to one display
// source at a time. Between two owners the panel is held at idle values for
// BLANK_CYCLES cycles, then one IDLE cycle arbitrates the next owner.
//
// Handshake: req[i] is a level held by source i for as long as it wants the
// panel. gnt is registered and one-hot (or zero); source i owns the panel
// while gnt[i] is high, and the panel shows its slice from the following
// cycle's registered outputs. Dropping req[i] releases the panel on the next
// edge. There is no queueing: a losing request simply stays pending.
//
// Build option: PANEL_ARB_PREEMPT_EN -- when defined, a higher-priority
// request takes the panel away from the owner once the hold counter is 0.
// When undefined, the owner keeps the panel until it drops its own req.
//
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   req       in  NREQ       : level requests, index 0 highest priority
//   seg_in/cat_in/hang_in/red_in/gre_in in 8*NREQ : per-source panel data
//   gnt       out NREQ       : registered one-hot grant
//   owner     out clog2(NREQ): current owner, meaningful while busy
//   busy      out 1          : grant held
//   seg/cat/hang/red/gre out 8 : registered panel outputs
//   dbg_state out 2          : FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module panel_arbiter
  import panel_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int MIN_HOLD     = MIN_HOLD_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [8*NREQ-1:0]         seg_in,
  input  logic [8*NREQ-1:0]         cat_in,
  input  logic [8*NREQ-1:0]         hang_in,
  input  logic [8*NREQ-1:0]         red_in,
  input  logic [8*NREQ-1:0]         gre_in,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic [7:0]                seg,
  output logic [7:0]                cat,
  output logic [7:0]                hang,
  output logic [7:0]                red,
  output logic [7:0]                gre,
  output logic [1:0]                dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blank_cnt;

  assign dbg_state = state;

  // Arbitration among all requesters, used in IDLE.
  logic            win_valid;
  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;

  prio_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick_idle (
    .req     (req),
    .mask_en (1'b0),
    .limit   ({IW{1'b0}}),
    .valid   (win_valid),
    .onehot  (win_onehot),
    .idx     (win_idx)
  );

  // Preemption request: someone outranking the owner wants the panel and
  // the owner has served its minimum hold (counter value before decrement).
  logic preempt;

`ifdef PANEL_ARB_PREEMPT_EN
  logic            hi_valid;
  logic [NREQ-1:0] hi_onehot;
  logic [IW-1:0]   hi_idx;
  logic            unused_hi;

  prio_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick_hi (
    .req     (req),
    .mask_en (1'b1),
    .limit   (owner),
    .valid   (hi_valid),
    .onehot  (hi_onehot),
    .idx     (hi_idx)
  );

  assign unused_hi = ^{hi_onehot, hi_idx};
  assign preempt   = (hold_cnt == '0) && hi_valid;
`else
  assign preempt = 1'b0;
`endif

  // Source whose data is loaded into the panel registers this edge: the
  // new winner when coming out of IDLE, otherwise the current owner.
  logic [IW-1:0] sel_idx;
  logic [7:0]    sel_seg, sel_cat, sel_hang, sel_red, sel_gre;

  always_comb begin
    sel_idx  = (state == OWN) ? owner : win_idx;
    sel_seg  = seg_in [sel_idx*8 +: 8];
    sel_cat  = cat_in [sel_idx*8 +: 8];
    sel_hang = hang_in[sel_idx*8 +: 8];
    sel_red  = red_in [sel_idx*8 +: 8];
    sel_gre  = gre_in [sel_idx*8 +: 8];
  end

  logic release_now;
  assign release_now = !req[owner] || preempt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      owner     <= '0;
      hold_cnt  <= '0;
      blank_cnt <= '0;
      seg       <= SEG_IDLE;
      cat       <= CAT_IDLE;
      hang      <= HANG_IDLE;
      red       <= RED_IDLE;
      gre       <= GRE_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= OWN;
            gnt      <= win_onehot;
            busy     <= 1'b1;
            owner    <= win_idx;
            hold_cnt <= HW'(MIN_HOLD);
            seg      <= sel_seg;
            cat      <= sel_cat;
            hang     <= sel_hang;
            red      <= sel_red;
            gre      <= sel_gre;
          end
        end

        OWN: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end
          if (release_now) begin
            state     <= BLANK;
            gnt       <= '0;
            busy      <= 1'b0;
            blank_cnt <= BW'(BLANK_CYCLES - 1);
            seg       <= SEG_IDLE;
            cat       <= CAT_IDLE;
            hang      <= HANG_IDLE;
            red       <= RED_IDLE;
            gre       <= GRE_IDLE;
          end else begin
            seg  <= sel_seg;
            cat  <= sel_cat;
            hang <= sel_hang;
            red  <= sel_red;
            gre  <= sel_gre;
          end
        end

        BLANK: begin
          // Loaded with BLANK_CYCLES-1 so the state lasts BLANK_CYCLES cycles.
          if (blank_cnt == '0) begin
            state <= IDLE;
          end else begin
            blank_cnt <= blank_cnt - BW'(1);
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          seg   <= SEG_IDLE;
          cat   <= CAT_IDLE;
          hang  <= HANG_IDLE;
          red   <= RED_IDLE;
          gre   <= GRE_IDLE;
        end
      endcase
    end
  end

endmodule
